// File: rtl/obstacle_scheduler.sv
// ---------------------------------------------------------------------------
// obstacle_scheduler
//
// Decides when an obstacle spawns and which kind (bird or cactus) it is for
// the dino-run game. A frame-counted gap separates consecutive obstacles. The
// gap is a base value plus a few random bits. The base shrinks with play time
// until it reaches a floor.
//
// Ports
//   clk_25_175_i    pixel clock (single clock domain)
//   rst_i           asynchronous, active-high reset
//   en_i            game is in PLAYING state
//   freeze_i        game is in HIT state: all state holds, no pulses
//   clear_i         synchronous restart: back to IDLE, difficulty ramp reset
//   next_frame_i    one-cycle pulse per frame
//   visible_i       VGA timer is inside the visible region
//   rand_i[15:0]    current LFSR value
//   lfsr_next_o     one-cycle pulse: advance the LFSR (combinational)
//   bird_spawn_o    one-cycle spawn pulse to the bird object (registered)
//   cactus_spawn_o  one-cycle spawn pulse to the cactus object (registered)
//   bird_rand_o     bird variant latched at bird spawn (rand_i[1:0])
//   cactus_rand_o   cactus variant latched at cactus spawn (rand_i[4:2])
//   gap_base_o      current base gap in frames
// ---------------------------------------------------------------------------
module obstacle_scheduler #(
    parameter int GAP_INIT       = 40,
    parameter int GAP_FLOOR      = 16,
    parameter int GAP_RAND_BITS  = 5,
    parameter int SPEEDUP_FRAMES = 600,
    parameter int BIRD_UNLOCK    = 300
) (
    input  logic        clk_25_175_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        freeze_i,
    input  logic        clear_i,
    input  logic        next_frame_i,
    input  logic        visible_i,
    input  logic [15:0] rand_i,
    output logic        lfsr_next_o,
    output logic        bird_spawn_o,
    output logic        cactus_spawn_o,
    output logic [1:0]  bird_rand_o,
    output logic [2:0]  cactus_rand_o,
    output logic [7:0]  gap_base_o
);

    localparam logic [7:0]  GAP_INIT_C    = 8'(GAP_INIT);
    localparam logic [7:0]  GAP_FLOOR_C   = 8'(GAP_FLOOR);
    localparam logic [15:0] RAMP_LAST_C   = 16'(SPEEDUP_FRAMES - 1);
    localparam logic [15:0] BIRD_UNLOCK_C = 16'(BIRD_UNLOCK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ARM  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [7:0]  gap_cnt_q;
    logic [7:0]  gap_base_q;
    logic [15:0] elapsed_q;
    logic [15:0] ramp_cnt_q;
    logic        bird_spawn_p1;
    logic        cactus_spawn_p1;
    logic [1:0]  bird_rand_q;
    logic [2:0]  cactus_rand_q;

    logic        go;
    logic        fire;
    logic        load_gap;
    logic        pick_bird;
    logic [7:0]  gap_load;
    logic        unused_rand;

    // Saturating frame counter step for the play-time counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // One difficulty step: shrink the base gap, never below the floor.
    function automatic logic [7:0] ramp_gap(input logic [7:0] base);
        return (base > GAP_FLOOR_C) ? base - 8'd1 : base;
    endfunction

    // Normal operation only when playing, not frozen and not restarting.
    assign go        = en_i & ~freeze_i & ~clear_i;
    // Spawn only during blanking so an obstacle never pops in mid-scanout.
    assign fire      = go & (state_q == ST_ARM) & ~visible_i;
    assign load_gap  = go & ((state_q == ST_IDLE) | fire);
    assign pick_bird = rand_i[15] & (elapsed_q >= BIRD_UNLOCK_C);
    // Cannot overflow: GAP_INIT + 2**GAP_RAND_BITS - 1 fits in 8 bits.
    assign gap_load  = gap_base_q + 8'(rand_i[GAP_RAND_BITS-1:0]);

    // Only some LFSR bits steer decisions; the rest are intentionally ignored.
    assign unused_rand = ^rand_i;

    // ---- FSM: state register ----
    always_ff @(posedge clk_25_175_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM: next-state logic ----
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = ST_IDLE;
        end else if (freeze_i) begin
            state_d = state_q;
        end else if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT;
                // A count of 0 or 1 both mean the gap expires on this frame.
                ST_WAIT: if (next_frame_i && (gap_cnt_q <= 8'd1)) state_d = ST_ARM;
                ST_ARM:  if (!visible_i) state_d = ST_WAIT;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ---- FSM: outputs ----
    // Spawn pulses are registered one cycle after the fire decision; a pulse
    // still pending while frozen is held in its register and shown on release.
    always_comb begin
        lfsr_next_o    = load_gap & ~rst_i;
        bird_spawn_o   = bird_spawn_p1 & go;
        cactus_spawn_o = cactus_spawn_p1 & go;
    end

    assign bird_rand_o   = bird_rand_q;
    assign cactus_rand_o = cactus_rand_q;
    assign gap_base_o    = gap_base_q;

    // ---- gap countdown, difficulty ramp, spawn pulse stage (_p1) ----
    always_ff @(posedge clk_25_175_i or posedge rst_i) begin
        if (rst_i) begin
            gap_cnt_q       <= 8'd0;
            gap_base_q      <= GAP_INIT_C;
            elapsed_q       <= 16'd0;
            ramp_cnt_q      <= 16'd0;
            bird_spawn_p1   <= 1'b0;
            cactus_spawn_p1 <= 1'b0;
            bird_rand_q     <= 2'd0;
            cactus_rand_q   <= 3'd0;
        end else if (clear_i) begin
            gap_base_q      <= GAP_INIT_C;
            elapsed_q       <= 16'd0;
            ramp_cnt_q      <= 16'd0;
            bird_spawn_p1   <= 1'b0;
            cactus_spawn_p1 <= 1'b0;
        end else if (!freeze_i) begin
            bird_spawn_p1   <= fire & pick_bird;
            cactus_spawn_p1 <= fire & ~pick_bird;
            if (en_i) begin
                // A frame arriving in the fire cycle does not count toward the new gap.
                if (load_gap) begin
                    gap_cnt_q <= gap_load;
                end else if ((state_q == ST_WAIT) && next_frame_i && (gap_cnt_q != 8'd0)) begin
                    gap_cnt_q <= gap_cnt_q - 8'd1;
                end

                if (fire) begin
                    if (pick_bird) begin
                        bird_rand_q <= rand_i[1:0];
                    end else begin
                        cactus_rand_q <= rand_i[4:2];
                    end
                end

                // A new base only affects the next load, never a running countdown.
                if (next_frame_i) begin
                    elapsed_q <= sat_inc16(elapsed_q);
                    if (ramp_cnt_q == RAMP_LAST_C) begin
                        ramp_cnt_q <= 16'd0;
                        gap_base_q <= ramp_gap(gap_base_q);
                    end else begin
                        ramp_cnt_q <= ramp_cnt_q + 16'd1;
                    end
                end
            end
        end
    end

endmodule
